// File: rtl/de2_flash_cmd_sequencer.sv
// Host command sequencer for the DE2 parallel NOR flash: expands read,
// program-byte, sector-erase and chip-erase requests into the JEDEC unlock
// write sequences, then polls DQ7/DQ5 until the embedded algorithm finishes.
// Optional build macro: FLASH_CMD_TIMEOUT_EN bounds the number of status
// reads per command to POLL_LIMIT (aborting with cmd_error=1 once reached).
module de2_flash_cmd_sequencer #(
  parameter logic [23:0] POLL_LIMIT = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cmd,
  input  logic [21:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_req,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic        cmd_error,
  output logic [7:0]  rd_data,
  output logic [21:0] m_address,
  output logic [7:0]  m_to_mem,
  output logic        m_wren,
  output logic        m_req,
  input  logic [7:0]  m_from_mem,
  input  logic        m_ready
);

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;

  localparam logic [1:0] CMD_READ = 2'b00;
  localparam logic [1:0] CMD_PROG = 2'b01;
  localparam logic [1:0] CMD_SECT = 2'b10;
  localparam logic [1:0] CMD_CHIP = 2'b11;

  localparam logic [AW-1:0] ADDR_AAA = 22'h000AAA;
  localparam logic [AW-1:0] ADDR_555 = 22'h000555;

  typedef enum logic [3:0] {
    IDLE, ISSUE, WAIT, POLL_ISSUE, POLL_WAIT,
    RECHECK_ISSUE, RECHECK_WAIT, ABORT_ISSUE, ABORT_WAIT, DONE
  } state_t;

  state_t        state;
  logic [1:0]    cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [SW-1:0] step;

  logic [AW-1:0] step_addr_c;
  logic [DW-1:0] step_data_c;
  logic          step_wren_c;
  logic          last_step_c;
  logic          exp_dq7_c;

`ifdef FLASH_CMD_TIMEOUT_EN
  localparam int unsigned PW = 24;
  logic [PW-1:0] poll_cnt;
`else
  logic unused_poll_limit;
  assign unused_poll_limit = ^POLL_LIMIT;
`endif

  // Bus cycle for the current step of the latched command's write/read sequence
  always_comb begin
    step_addr_c = addr_q;
    step_data_c = data_q;
    step_wren_c = 1'b1;
    last_step_c = 1'b0;
    unique case (cmd_q)
      CMD_READ: begin
        step_wren_c = 1'b0;
        last_step_c = 1'b1;
      end
      CMD_PROG: begin
        case (step)
          3'd0:    begin step_addr_c = ADDR_AAA; step_data_c = 8'hAA; end
          3'd1:    begin step_addr_c = ADDR_555; step_data_c = 8'h55; end
          3'd2:    begin step_addr_c = ADDR_AAA; step_data_c = 8'hA0; end
          default: last_step_c = 1'b1;
        endcase
      end
      CMD_SECT, CMD_CHIP: begin
        case (step)
          3'd0:    begin step_addr_c = ADDR_AAA; step_data_c = 8'hAA; end
          3'd1:    begin step_addr_c = ADDR_555; step_data_c = 8'h55; end
          3'd2:    begin step_addr_c = ADDR_AAA; step_data_c = 8'h80; end
          3'd3:    begin step_addr_c = ADDR_AAA; step_data_c = 8'hAA; end
          3'd4:    begin step_addr_c = ADDR_555; step_data_c = 8'h55; end
          default: begin
            last_step_c = 1'b1;
            step_addr_c = (cmd_q == CMD_CHIP) ? ADDR_AAA : addr_q;
            step_data_c = (cmd_q == CMD_CHIP) ? 8'h10 : 8'h30;
          end
        endcase
      end
    endcase
  end

  // Completed embedded algorithm drives DQ7 to the true data bit (program) or 1 (erase)
  always_comb begin
    exp_dq7_c = (cmd_q == CMD_PROG) ? data_q[7] : 1'b1;
  end

  // Command FSM with registered host and flash-port outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_q     <= 2'b00;
      addr_q    <= '0;
      data_q    <= '0;
      step      <= '0;
      cmd_busy  <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_error <= 1'b0;
      rd_data   <= '0;
      m_address <= '0;
      m_to_mem  <= '0;
      m_wren    <= 1'b0;
      m_req     <= 1'b0;
`ifdef FLASH_CMD_TIMEOUT_EN
      poll_cnt  <= '0;
`endif
    end else begin
      m_req    <= 1'b0;
      cmd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_req) begin
            cmd_q     <= cmd;
            addr_q    <= cmd_addr;
            data_q    <= cmd_data;
            step      <= '0;
            cmd_busy  <= 1'b1;
            cmd_error <= 1'b0;
`ifdef FLASH_CMD_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          m_address <= step_addr_c;
          m_to_mem  <= step_data_c;
          m_wren    <= step_wren_c;
          m_req     <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (m_ready) begin
            if (!last_step_c) begin
              step  <= step + SW'(1);
              state <= ISSUE;
            end else if (cmd_q == CMD_READ) begin
              rd_data   <= m_from_mem;
              cmd_error <= 1'b0;
              cmd_done  <= 1'b1;
              cmd_busy  <= 1'b0;
              state     <= DONE;
            end else begin
              state <= POLL_ISSUE;
            end
          end
        end
        POLL_ISSUE: begin
          m_address <= addr_q;
          m_wren    <= 1'b0;
          m_req     <= 1'b1;
`ifdef FLASH_CMD_TIMEOUT_EN
          poll_cnt  <= poll_cnt + PW'(1);
`endif
          state     <= POLL_WAIT;
        end
        POLL_WAIT: begin
          if (m_ready) begin
            if (m_from_mem[7] == exp_dq7_c) begin
              cmd_error <= 1'b0;
              cmd_done  <= 1'b1;
              cmd_busy  <= 1'b0;
              state     <= DONE;
            end else if (m_from_mem[5]) begin
              state <= RECHECK_ISSUE;
`ifdef FLASH_CMD_TIMEOUT_EN
            end else if (poll_cnt >= POLL_LIMIT) begin
              state <= ABORT_ISSUE;
`endif
            end else begin
              state <= POLL_ISSUE;
            end
          end
        end
        RECHECK_ISSUE: begin
          m_address <= addr_q;
          m_wren    <= 1'b0;
          m_req     <= 1'b1;
          state     <= RECHECK_WAIT;
        end
        RECHECK_WAIT: begin
          if (m_ready) begin
            if (m_from_mem[7] == exp_dq7_c) begin
              cmd_error <= 1'b0;
              cmd_done  <= 1'b1;
              cmd_busy  <= 1'b0;
              state     <= DONE;
            end else begin
              state <= ABORT_ISSUE;
            end
          end
        end
        ABORT_ISSUE: begin
          m_address <= '0;
          m_to_mem  <= 8'hF0;
          m_wren    <= 1'b1;
          m_req     <= 1'b1;
          state     <= ABORT_WAIT;
        end
        ABORT_WAIT: begin
          if (m_ready) begin
            cmd_error <= 1'b1;
            cmd_done  <= 1'b1;
            cmd_busy  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_de2_flash_cmd_sequencer.sv
// Bench for de2_flash_cmd_sequencer: a randomized-latency flash responder
// plays scripted status bytes; a transaction-level model predicts the bus
// trace, error flag and read data for each command.
`timescale 1ns/1ps
module tb_de2_flash_cmd_sequencer;

  localparam logic [23:0] TB_POLL_LIMIT = 24'd8;
  localparam logic [1:0]  C_READ = 2'b00;
  localparam logic [1:0]  C_PROG = 2'b01;
  localparam logic [1:0]  C_SECT = 2'b10;
  localparam logic [1:0]  C_CHIP = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd;
  logic [21:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_req;
  logic        cmd_busy, cmd_done, cmd_error;
  logic [7:0]  rd_data;
  logic [21:0] m_address;
  logic [7:0]  m_to_mem;
  logic        m_wren, m_req;
  logic [7:0]  m_from_mem;
  logic        m_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [21:0] log_addr[$];
  logic [7:0]  log_data[$];
  logic        log_wren[$];
  logic [7:0]  resp_q[$];

  logic [21:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic        exp_wren[$];
  logic        exp_err;
  logic [7:0]  exp_rd;

  always #5 clk = ~clk;

  de2_flash_cmd_sequencer #(.POLL_LIMIT(TB_POLL_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_req(cmd_req), .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_error(cmd_error),
    .rd_data(rd_data), .m_address(m_address), .m_to_mem(m_to_mem), .m_wren(m_wren),
    .m_req(m_req), .m_from_mem(m_from_mem), .m_ready(m_ready)
  );

  // Flash controller stand-in: logs every request, answers after 1-3 cycles
  initial begin
    logic w;
    m_ready    = 1'b0;
    m_from_mem = 8'h00;
    forever begin
      @(posedge clk); #1;
      m_ready = 1'b0;
      if (m_req) begin
        w = m_wren;
        log_addr.push_back(m_address);
        log_data.push_back(m_to_mem);
        log_wren.push_back(w);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (!w && resp_q.size() > 0) m_from_mem = resp_q.pop_front();
        else m_from_mem = 8'($urandom);
        m_ready = 1'b1;
      end
    end
  end

  function automatic logic [7:0] mk_status(input logic dq7, input logic dq5);
    logic [7:0] s;
    s    = 8'($urandom);
    s[7] = dq7;
    s[5] = dq5;
    return s;
  endfunction

  task automatic exp_push(input logic [21:0] a, input logic [7:0] d, input logic w);
    exp_addr.push_back(a);
    exp_data.push_back(d);
    exp_wren.push_back(w);
  endtask

  // Transaction-level prediction from the scripted responses in resp_q
  task automatic model_cmd(input logic [1:0] c, input logic [21:0] a, input logic [7:0] d);
    logic       want, ok, abort;
    logic [7:0] s;
    int         idx, nreads;
    exp_addr.delete(); exp_data.delete(); exp_wren.delete();
    exp_err = 1'b0;
    exp_rd  = 8'h00;
    if (c == C_READ) begin
      exp_push(a, 8'h00, 1'b0);
      exp_rd = (resp_q.size() > 0) ? resp_q[0] : 8'h00;
      return;
    end
    exp_push(22'hAAA, 8'hAA, 1'b1);
    exp_push(22'h555, 8'h55, 1'b1);
    if (c == C_PROG) begin
      exp_push(22'hAAA, 8'hA0, 1'b1);
      exp_push(a, d, 1'b1);
    end else begin
      exp_push(22'hAAA, 8'h80, 1'b1);
      exp_push(22'hAAA, 8'hAA, 1'b1);
      exp_push(22'h555, 8'h55, 1'b1);
      if (c == C_CHIP) exp_push(22'hAAA, 8'h10, 1'b1);
      else             exp_push(a, 8'h30, 1'b1);
    end
    want = (c == C_PROG) ? d[7] : 1'b1;
    idx = 0; nreads = 0; ok = 1'b0; abort = 1'b0;
    while (!ok && !abort && nreads < 1000) begin
      s = (idx < resp_q.size()) ? resp_q[idx] : 8'h00;
      idx++; nreads++;
      exp_push(a, 8'h00, 1'b0);
      if (s[7] == want) ok = 1'b1;
      else if (s[5]) begin
        s = (idx < resp_q.size()) ? resp_q[idx] : 8'h00;
        idx++;
        exp_push(a, 8'h00, 1'b0);
        if (s[7] == want) ok = 1'b1;
        else abort = 1'b1;
      end
`ifdef FLASH_CMD_TIMEOUT_EN
      else if (nreads >= int'(TB_POLL_LIMIT)) abort = 1'b1;
`endif
    end
    if (abort) exp_push(22'h0, 8'hF0, 1'b1);
    exp_err = abort;
  endtask

  task automatic plan_poll(input logic want, input int n_mis, input int dq5_pct);
    for (int i = 0; i < n_mis; i++)
      resp_q.push_back(mk_status(~want, ($urandom_range(0, 99) < dq5_pct)));
    resp_q.push_back(mk_status(want, 1'($urandom)));
  endtask

  // Issue one command, wait for completion and compare against the model
  task automatic run_cmd(input string tag, input logic [1:0] c, input logic [21:0] a,
                         input logic [7:0] d);
    logic accepted, got_done, busy_gap, mreq_double, prev_mreq, bad;
    model_cmd(c, a, d);
    log_addr.delete(); log_data.delete(); log_wren.delete();
    cmd = c; cmd_addr = a; cmd_data = d; cmd_req = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin @(posedge clk); #1; accepted = cmd_busy; end
    cmd_req = 1'b0;
    got_done = 1'b0; busy_gap = 1'b0; mreq_double = 1'b0; prev_mreq = 1'b0;
    if (accepted) begin
      for (int i = 0; i < 5000 && !got_done; i++) begin
        @(posedge clk); #1;
        if (prev_mreq && m_req) mreq_double = 1'b1;
        prev_mreq = m_req;
        if (cmd_done) got_done = 1'b1;
        else if (!cmd_busy) busy_gap = 1'b1;
      end
    end
    n_cmp++;
    if (!(accepted && got_done)) begin
      n_fail++;
      $display("FAIL %s handshake: accepted=%0b done=%0b, required 1/1", tag, accepted, got_done);
      return;
    end
    n_cmp++;
    if (cmd_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_at_done: got %b required 0", tag, cmd_busy);
    end
    n_cmp++;
    if (cmd_error !== exp_err) begin
      n_fail++; $display("FAIL %s error: got %b required %b", tag, cmd_error, exp_err);
    end
    if (c == C_READ) begin
      n_cmp++;
      if (rd_data !== exp_rd) begin
        n_fail++; $display("FAIL %s rd_data: got %h required %h", tag, rd_data, exp_rd);
      end
    end
    n_cmp++;
    if (busy_gap || mreq_double) begin
      n_fail++;
      $display("FAIL %s protocol: busy_gap=%0b mreq_double=%0b required 0/0", tag, busy_gap, mreq_double);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (cmd_done !== 1'b0 || cmd_error !== exp_err || (c == C_READ && rd_data !== exp_rd)) begin
      n_fail++;
      $display("FAIL %s hold: done=%b err=%b rd=%h required 0/%b/%h", tag, cmd_done, cmd_error,
               rd_data, exp_err, exp_rd);
    end
    n_cmp++;
    if (log_addr.size() != exp_addr.size()) begin
      n_fail++;
      $display("FAIL %s trace_len: got %0d required %0d", tag, log_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        bad = (log_addr[i] !== exp_addr[i]) || (log_wren[i] !== exp_wren[i]) ||
              (exp_wren[i] && log_data[i] !== exp_data[i]);
        n_cmp++;
        if (bad) begin
          n_fail++;
          $display("FAIL %s trace[%0d]: got %h/%h/w%b required %h/%h/w%b", tag, i, log_addr[i],
                   log_data[i], log_wren[i], exp_addr[i], exp_data[i], exp_wren[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_req = 1'b1; cmd = 2'($urandom); cmd_addr = 22'($urandom);
    cmd_data = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({cmd_busy, cmd_done, cmd_error, rd_data, m_address, m_to_mem, m_wren, m_req} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b rd=%h addr=%h wd=%h wren=%b req=%b required all 0",
               cmd_busy, cmd_done, cmd_error, rd_data, m_address, m_to_mem, m_wren, m_req);
    end
    cmd_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (cmd_busy !== 1'b0 || m_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b req=%b required 0/0", cmd_busy, m_req);
    end
  endtask

  task automatic test_read();
    resp_q.delete(); resp_q.push_back(8'h5A);
    run_cmd("read_directed", C_READ, 22'h012345, 8'h00);
    for (int k = 0; k < 4; k++) begin
      resp_q.delete(); resp_q.push_back(8'($urandom));
      run_cmd("read_random", C_READ, 22'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_program();
    resp_q.delete();
    for (int i = 0; i < 3; i++) resp_q.push_back(mk_status(1'b1, 1'b0));
    resp_q.push_back(mk_status(1'b0, 1'b0));
    run_cmd("program_directed", C_PROG, 22'h000100, 8'h3C);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      resp_q.delete();
      plan_poll(d[7], $urandom_range(0, 6), 0);
      run_cmd("program_random", C_PROG, 22'($urandom), d);
    end
  endtask

  task automatic test_erase();
    resp_q.delete();
    for (int i = 0; i < 5; i++) resp_q.push_back(mk_status(1'b0, 1'b0));
    resp_q.push_back(mk_status(1'b1, 1'b0));
    run_cmd("sector_erase_directed", C_SECT, 22'h010000, 8'h00);
    for (int k = 0; k < 4; k++) begin
      resp_q.delete();
      plan_poll(1'b1, $urandom_range(0, 6), 0);
      run_cmd("erase_random", (k[0] ? C_CHIP : C_SECT), 22'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_dq5_fail();
    resp_q.delete();
    resp_q.push_back(mk_status(1'b1, 1'b1));
    resp_q.push_back(mk_status(1'b1, 1'b1));
    run_cmd("dq5_abort", C_PROG, 22'h000200, 8'h3C);
    resp_q.delete();
    resp_q.push_back(mk_status(1'b0, 1'b1));
    resp_q.push_back(mk_status(1'b1, 1'b0));
    run_cmd("dq5_recheck_ok", C_SECT, 22'h020000, 8'h00);
    for (int k = 0; k < 6; k++) begin
      logic [7:0] d;
      logic [1:0] c;
      d = 8'($urandom);
      c = 2'($urandom_range(1, 3));
      resp_q.delete();
      plan_poll((c == C_PROG) ? d[7] : 1'b1, $urandom_range(1, 5), 30);
      run_cmd("dq5_random", c, 22'($urandom), d);
    end
  endtask

`ifdef FLASH_CMD_TIMEOUT_EN
  task automatic test_timeout();
    resp_q.delete();
    for (int i = 0; i < 20; i++) resp_q.push_back(mk_status(1'b0, 1'b0));
    run_cmd("timeout", C_CHIP, 22'h000000, 8'h00);
  endtask
`endif

  task automatic test_reset_mid();
    logic hit;
    resp_q.delete();
    plan_poll(1'b1, 2, 0);
    log_addr.delete(); log_data.delete(); log_wren.delete();
    cmd = C_CHIP; cmd_addr = 22'h000000; cmd_data = 8'h00; cmd_req = 1'b1;
    @(posedge clk); #1;
    cmd_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin @(posedge clk); #2; hit = (log_addr.size() >= 3); end
    n_cmp++;
    if (!hit) begin
      n_fail++; $display("FAIL reset_mid_reach_step2: got %0d requests required 3", log_addr.size());
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({cmd_busy, cmd_done, cmd_error, rd_data, m_address, m_to_mem, m_wren, m_req} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b err=%b rd=%h addr=%h wd=%h wren=%b req=%b required all 0",
               cmd_busy, cmd_done, cmd_error, rd_data, m_address, m_to_mem, m_wren, m_req);
    end
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    n_cmp++;
    if (log_addr.size() != 3 || cmd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_abort: requests=%0d busy=%b required 3/0", log_addr.size(), cmd_busy);
    end
    resp_q.delete(); resp_q.push_back(8'hC3);
    run_cmd("read_after_reset", C_READ, 22'h2ABCDE, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, r1;
    logic got;
    r0 = 8'($urandom); r1 = 8'($urandom);
    resp_q.delete(); resp_q.push_back(r0); resp_q.push_back(r1);
    log_addr.delete(); log_data.delete(); log_wren.delete();
    cmd = C_READ; cmd_addr = 22'($urandom); cmd_data = 8'h00; cmd_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin @(posedge clk); #1; got = cmd_done; end
    n_cmp++;
    if (!got || rd_data !== r0) begin
      n_fail++; $display("FAIL b2b_first: done=%b rd=%h required 1/%h", got, rd_data, r0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (cmd_busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done_ignored: busy=%b required 0", cmd_busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (cmd_busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_reaccept: busy=%b required 1", cmd_busy);
    end
    cmd_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin @(posedge clk); #1; got = cmd_done; end
    n_cmp++;
    if (!got || rd_data !== r1 || cmd_error !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b rd=%h err=%b required 1/%h/0", got, rd_data, cmd_error, r1);
    end
    repeat (4) @(posedge clk);
    #2;
    n_cmp++;
    if (log_addr.size() != 2 || cmd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count: requests=%0d busy=%b required 2/0", log_addr.size(), cmd_busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_req = 1'b0; cmd = 2'b00; cmd_addr = '0; cmd_data = '0;
    test_reset();
    test_read();
    test_program();
    test_erase();
    test_dq5_fail();
`ifdef FLASH_CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
